// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit with architectural HI/LO.
// mult/multu/div/divu have a fixed latency. Their result is computed at
// launch, parked in TMP_HI/TMP_LO, and committed when the busy countdown ends.
// mfhi/mflo read HI/LO combinationally on MD_Out. mthi/mtlo write in one cycle.
// Optional feature macro: MDU_FAST_ZERO_EN. When it is defined, a multiply
// by zero or a divide by zero finishes after one busy cycle.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MD_Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_Out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // Signed 32x32 -> 64 product.
    function automatic logic [63:0] mul_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] ax;
        logic signed [63:0] bx;
        logic signed [63:0] p;
        ax = a;
        bx = b;
        p  = ax * bx;
        return p;
    endfunction

    // Unsigned 32x32 -> 64 product.
    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = {32'd0, a};
        bx = {32'd0, b};
        return ax * bx;
    endfunction

    // Signed divide, returned as {remainder, quotient}.
    // The division is done on magnitudes, so the quotient truncates toward
    // zero and the remainder takes the dividend's sign. 0x80000000 / -1 wraps
    // to 0x80000000 with a remainder of 0. The caller never passes b == 0.
    function automatic logic [63:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? 32'(-a) : 32'(a);
        mb = b[31] ? 32'(-b) : 32'(b);
        q  = ma / mb;
        r  = ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    // Unsigned divide, returned as {remainder, quotient}.
    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      tmp_hi_q;
    logic [31:0]      tmp_lo_q;
    logic             wr_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;

    logic             launch_d;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      tmp_hi_d;
    logic [31:0]      tmp_lo_d;
    logic             wr_d;
    logic [31:0]      b_safe;
    logic [63:0]      res;

    // Launch decode: full 64-bit result, busy length, and whether HI/LO get written.
    always_comb begin
        launch_d = 1'b0;
        cnt_d    = '0;
        wr_d     = 1'b1;
        res      = 64'd0;
        b_safe   = (B == 32'd0) ? 32'd1 : B;
        case (MD_Op)
            OP_MULT: begin
                launch_d = 1'b1;
                res      = mul_s(A, B);
                cnt_d    = CNT_W'(MULT_CYCLES);
`ifdef MDU_FAST_ZERO_EN
                if (A == 32'd0 || B == 32'd0) cnt_d = CNT_W'(1);
`endif
            end
            OP_MULTU: begin
                launch_d = 1'b1;
                res      = mul_u(A, B);
                cnt_d    = CNT_W'(MULT_CYCLES);
`ifdef MDU_FAST_ZERO_EN
                if (A == 32'd0 || B == 32'd0) cnt_d = CNT_W'(1);
`endif
            end
            OP_DIV: begin
                launch_d = 1'b1;
                res      = div_s(A, b_safe);
                wr_d     = (B != 32'd0);
                cnt_d    = CNT_W'(DIV_CYCLES);
`ifdef MDU_FAST_ZERO_EN
                if (B == 32'd0) cnt_d = CNT_W'(1);
`endif
            end
            OP_DIVU: begin
                launch_d = 1'b1;
                res      = div_u(A, b_safe);
                wr_d     = (B != 32'd0);
                cnt_d    = CNT_W'(DIV_CYCLES);
`ifdef MDU_FAST_ZERO_EN
                if (B == 32'd0) cnt_d = CNT_W'(1);
`endif
            end
            default: launch_d = 1'b0;
        endcase
        tmp_hi_d = res[63:32];
        tmp_lo_d = res[31:0];
    end

    // Busy countdown, commit into HI/LO, launch, and mthi/mtlo writes.
    // A Start that arrives while busy is ignored so the pending result stays intact.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            tmp_hi_q <= 32'd0;
            tmp_lo_q <= 32'd0;
            wr_q     <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else if (busy_q) begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
                if (wr_q) begin
                    hi_q <= tmp_hi_q;
                    lo_q <= tmp_lo_q;
                end
            end
        end else if (Start) begin
            if (launch_d) begin
                busy_q   <= 1'b1;
                cnt_q    <= cnt_d;
                tmp_hi_q <= tmp_hi_d;
                tmp_lo_q <= tmp_lo_d;
                wr_q     <= wr_d;
            end else if (MD_Op == OP_MTHI) begin
                hi_q <= A;
            end else if (MD_Op == OP_MTLO) begin
                lo_q <= A;
            end
        end
    end

    // mfhi/mflo read port; it reads only the architectural HI/LO.
    always_comb begin
        MD_Out = 32'd0;
        if (MD_Op == OP_MFHI)      MD_Out = hi_q;
        else if (MD_Op == OP_MFLO) MD_Out = lo_q;
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench for mult_div_unit with a scoreboard queue of expected {HI,LO}.
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MDU_FAST_ZERO_EN
    localparam int MZ = 1;
    localparam int DZ = 1;
`else
    localparam int MZ = MC;
    localparam int DZ = DC;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [3:0]  MD_Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MD_Out;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] exp_q[$];
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MD_Op(MD_Op), .A(A), .B(B),
        .Busy(Busy), .HI(HI), .LO(LO), .MD_Out(MD_Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one Start cycle; returns at the negedge of the first cycle after the launch edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1; MD_Op = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; MD_Op = 4'd0; A = 32'd0; B = 32'd0;
    endtask

    // Count remaining busy cycles, check HI/LO held meanwhile, then compare against the scoreboard.
    task automatic wait_done(input string tag, input int exp_n);
        int          n = 0;
        logic [31:0] bad = 32'd0;
        logic [63:0] e;
        while (Busy === 1'b1 && n < 200) begin
            if (HI !== model_hi || LO !== model_lo) bad = 32'd1;
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
        chk({tag, "_hold"}, bad, 32'd0);
        e = exp_q.pop_front();
        chk({tag, "_hi"}, HI, e[63:32]);
        chk({tag, "_lo"}, LO, e[31:0]);
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int exp_n);
        exp_q.push_back({eh, el});
        launch(op, a, b);
        wait_done(tag, exp_n);
    endtask

    task automatic chk_md(input string tag, input logic [3:0] op, input logic [31:0] exp);
        @(negedge clk);
        MD_Op = op;
        #1;
        chk(tag, MD_Out, exp);
        MD_Op = 4'd0;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MD_Op = 4'd0; A = 32'd0; B = 32'd0;
        model_hi = 32'd0; model_lo = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk_md("rst_mfhi", 4'd5, 32'd0);

        run_op("mult",   4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, MC);
        run_op("multu",  4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, MC);
        run_op("div",    4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, DC);
        run_op("divu",   4'd4, 32'd7, 32'd2, 32'd1, 32'd3, DC);
        run_op("div_nd", 4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, DC);
        run_op("div_ov", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, DC);
        run_op("multu_big", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MC);
        chk_md("mfhi_after", 4'd5, 32'hFFFFFFFE);

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        Start = 1'b1; MD_Op = 4'd7; A = 32'h12345678;
        @(negedge clk);
        chk("mthi_busy", {31'd0, Busy}, 32'd0);
        MD_Op = 4'd8; A = 32'h9ABCDEF0;
        @(negedge clk);
        chk("mtlo_busy", {31'd0, Busy}, 32'd0);
        Start = 1'b0; MD_Op = 4'd0; A = 32'd0;
        chk_md("mt_mfhi", 4'd5, 32'h12345678);
        chk_md("mt_mflo", 4'd6, 32'h9ABCDEF0);
        chk_md("mt_none", 4'd0, 32'd0);
        model_hi = 32'h12345678; model_lo = 32'h9ABCDEF0;

        // ops 0 and 9 change nothing
        launch(4'd9, 32'hDEADBEEF, 32'd1);
        chk("op9_busy", {31'd0, Busy}, 32'd0);
        launch(4'd0, 32'hDEADBEEF, 32'd1);
        chk("op0_hi", HI, 32'h12345678);
        chk("op0_lo", LO, 32'h9ABCDEF0);

        // divide by zero leaves HI/LO alone
        launch(4'd7, 32'h55, 32'd0);
        launch(4'd8, 32'h55, 32'd0);
        model_hi = 32'h55; model_lo = 32'h55;
        run_op("div0",  4'd3, 32'd9, 32'd0, 32'h55, 32'h55, DZ);
        run_op("divu0", 4'd4, 32'd9, 32'd0, 32'h55, 32'h55, DZ);
        run_op("mult0", 4'd1, 32'd0, 32'd5, 32'd0, 32'd0, MZ);

        // Start of mthi/mtlo while busy is ignored
        launch(4'd7, 32'h77, 32'd0);
        model_hi = 32'h77;
        exp_q.push_back({32'd0, 32'd6});
        launch(4'd1, 32'd2, 32'd3);
        Start = 1'b1; MD_Op = 4'd7; A = 32'hDEAD0000;
        @(negedge clk);
        MD_Op = 4'd8;
        @(negedge clk);
        Start = 1'b0; MD_Op = 4'd0; A = 32'd0;
        chk("stray_hi", HI, 32'h77);
        chk("stray_lo", LO, 32'd0);
        wait_done("mult_stray", MC - 2);

        // reset during the third busy cycle discards the operation
        launch(4'd7, 32'h55, 32'd0);
        launch(4'd8, 32'h55, 32'd0);
        launch(4'd1, 32'd4, 32'd4);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        repeat (MC + 2) @(negedge clk);
        chk("rstmid_lo_late", LO, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit for the 5-stage MIPS pipeline. It executes mult/multu/div/divu with a fixed multi-cycle latency, holds the HI/LO registers, and serves mfhi/mflo/mthi/mtlo.
- It feeds the hazard-control logic through `Busy`. The hazard logic stalls F/D and clears E whenever the D-stage instruction uses HI/LO and (`Busy` or `Start`) is high.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (>=1)
- DIV_CYCLES, 10, number of busy cycles for div/divu (>=1)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  E-stage instruction valid and MD_Op is to be executed this cycle
- MD_Op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 are treated as none
- A  input  32  forwarded rs value (SrcA_E after bypass)
- B  input  32  forwarded rt value (SrcB_E after bypass)
- Busy  output  1  an operation is in flight
- HI  output  32  architectural HI register
- LO  output  32  architectural LO register
- MD_Out  output  32  read data for mfhi/mflo, to the E-stage result mux

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high. On a reset edge: `Busy`=0, `HI`=0, `LO`=0, cycle counter=0, temporary result registers=0. A reset during an operation discards that operation; HI/LO end up 0, not the pending result.
- Launch: at a `clk` edge with `Start`=1, `Busy`=0 and MD_Op in 1..4:
  - the full 64-bit result is computed from A/B and latched into TMP_HI/TMP_LO;
  - the counter is loaded with MULT_CYCLES or DIV_CYCLES;
  - `Busy` goes to 1 at that same edge.
- Countdown: each edge with `Busy`=1 decrements the counter. At the edge where the counter goes from 1 to 0: HI<=TMP_HI, LO<=TMP_LO, `Busy`<=0.
- Timing: if the launch edge is t0, `Busy` is high for exactly N cycles (t0+1..t0+N). The new HI/LO are visible from cycle t0+N+1, the same cycle `Busy` drops.
- Arithmetic:
  - mult: signed 32x32 -> 64; multu: unsigned. HI=product[63:32], LO=product[31:0].
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned; LO=quotient, HI=remainder.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, div or divu): the operation still occupies DIV_CYCLES, then HI and LO are left unchanged.
- mthi/mtlo: at a `clk` edge with `Start`=1, `Busy`=0, op 7 or 8: HI<=A or LO<=A respectively. This takes effect next cycle, and `Busy` stays 0.
- `Start` while `Busy`=1: ignored for every op. The hazard logic guarantees this does not happen for 1..8; the unit must tolerate it without corrupting state.
- MD_Out is combinational:
  - HI when MD_Op=5, LO when MD_Op=6, otherwise 0;
  - it does not depend on `Start` or `Busy`;
  - it reads the architectural HI/LO, never TMP.
- mfhi issued the cycle after `Busy` falls must see the new HI; there is no internal bypass beyond this.
- Op 0 or 9-15 with `Start`=1: no state change.

Optional Feature:
- Macro: MDU_FAST_ZERO_EN
- Defined:
  - mult/multu with A=0 or B=0 completes with 1 busy cycle (HI=LO=0);
  - div/divu with B=0 completes with 1 busy cycle (HI/LO unchanged);
  - `Busy` high for exactly cycle t0+1 in both cases.
- Undefined: these cases take the full MULT_CYCLES or DIV_CYCLES.
- All other behaviour is identical either way.

Test Plan:
- Reset, then idle: HI=LO=0, `Busy`=0, MD_Out=0 for MD_Op=5.
- mult A=0xFFFFFFFE(-2), B=3, Start 1 cycle -> `Busy` high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same with multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9(-7), B=2 -> `Busy` high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 -> LO=3, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> `Busy` stays 0; MD_Out for op5=0x12345678 and op6=0x9ABCDEF0.
- div B=0 after HI=LO=0x55 -> `Busy` high 10 cycles (1 with MDU_FAST_ZERO_EN); HI=LO=0x55 afterwards.
- mult started, then reset asserted on cycle 3 of Busy -> next cycle `Busy`=0, HI=LO=0. A Start with op mthi issued while `Busy`=1 leaves HI unchanged.
